rst_sequencer: RTL and testbench

Reset sequencer sitting directly downstream of the watchdog: consumes its two bite outputs (`wdt_out`) and `force_recovery_mode`, plus a software reset request, and drives the board reset line with a programmable-width pulse followed by a hold-off window. It keeps a persistent reset-cause register and a saturating bite counter. Both are readable over the shared CSR bus and survive the reset pulse it generates. It is clocked by the system clock, counts in the same `ce` tick domain as the watchdog, and is reset only by power-on reset.

---
 rtl/rst_sequencer_pkg.sv | 25 ++
 rtl/rst_sequencer_if.sv | 10 +
 rtl/rst_sequencer_tick_countdown.sv | 33 +++
 rtl/rst_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: CSR offsets, CAUSE bit positions,
// FSM state encoding and a small helper for "zero means one" counts.
package rst_sequencer_pkg;

    localparam logic [1:0] R_CTRL  = 2'd0;
    localparam logic [1:0] R_CAUSE = 2'd1;
    localparam logic [1:0] R_WIDTH = 2'd2;
    localparam logic [1:0] R_CNT   = 2'd3;

    localparam int C_WDT0 = 0;
    localparam int C_WDT1 = 1;
    localparam int C_SW   = 2;
    localparam int C_REC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// CSR bus shared by the reset sequencer and its bus master.
interface rst_sequencer_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (output csr_a, output csr_di, output csr_we, input csr_do);
    modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/rst_sequencer_tick_countdown.sv
// Loadable down-counter in the ce tick domain; done flags the tick that ends
// a count of 1. Shared by the pulse and hold-off phases.
module tick_countdown (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (ce && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    assign done = ce && (cnt_q == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: turns watchdog bites and software requests into a
// programmable low pulse plus hold-off, with a sticky cause register and bite counter.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h4,
    parameter logic [7:0] DFL_WIDTH = 8'h10,
    parameter logic [7:0] HOLDOFF   = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    rst_sequencer_if.slave        csr,
    input  logic [1:0]            wdt_out,
    input  logic                  force_recovery_mode,
    output logic                  soc_rst_n,
    output logic                  busy
);

    logic [4:0] csr_off_full;
    logic       csr_hit;
    logic [1:0] csr_off;
    logic       wr_ctrl, wr_cause, wr_width, wr_cnt;

    assign csr_off_full = csr.csr_a - BASE_ADDR;
    assign csr_hit      = (csr_off_full[4:2] == 3'd0);
    assign csr_off      = csr_off_full[1:0];
    assign wr_ctrl      = csr.csr_we && csr_hit && (csr_off == R_CTRL);
    assign wr_cause     = csr.csr_we && csr_hit && (csr_off == R_CAUSE);
    assign wr_width     = csr.csr_we && csr_hit && (csr_off == R_WIDTH);
    assign wr_cnt       = csr.csr_we && csr_hit && (csr_off == R_CNT);

    logic [1:0] wdt_q;
    logic [1:0] wdt_en_q, wdt_en_d;
    logic [3:0] cause_q, cause_d;
    logic [7:0] width_q, width_d;
    logic [7:0] bite_cnt_q, bite_cnt_d;
    logic [1:0] wdt_req;
    logic       sw_req, wdt_any, any_req;

    // Edge detect against the registered level so a stuck bite fires only once.
    for (genvar gi = 0; gi < 2; gi++) begin : g_wdt_edge
        assign wdt_req[gi] = wdt_out[gi] && !wdt_q[gi] && wdt_en_q[gi];
    end

    assign sw_req  = wr_ctrl && csr.csr_di[0];
    assign wdt_any = |wdt_req;
    assign any_req = wdt_any || sw_req;

    always_comb begin
        wdt_en_d = wdt_en_q;
        width_d  = width_q;
        if (wr_ctrl) begin
            wdt_en_d = csr.csr_di[2:1];
        end
        if (wr_width) begin
            width_d = csr.csr_di;
        end

        // Clear first, then set, so a same-cycle request is never lost.
        cause_d = cause_q;
        if (wr_cause) begin
            cause_d = cause_q & ~csr.csr_di[3:0];
        end
        cause_d[C_WDT0] = cause_d[C_WDT0] | wdt_req[0];
        cause_d[C_WDT1] = cause_d[C_WDT1] | wdt_req[1];
        cause_d[C_SW]   = cause_d[C_SW]   | sw_req;
        cause_d[C_REC]  = cause_d[C_REC]  | (any_req && force_recovery_mode);

        bite_cnt_d = bite_cnt_q;
        if (wdt_any) begin
            if (wr_cnt) begin
                bite_cnt_d = 8'd1;
            end else if (bite_cnt_q != 8'hff) begin
                bite_cnt_d = bite_cnt_q + 8'd1;
            end
        end else if (wr_cnt) begin
            bite_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q      <= 2'b00;
            wdt_en_q   <= 2'b11;
            cause_q    <= 4'd0;
            width_q    <= DFL_WIDTH;
            bite_cnt_q <= 8'd0;
        end else begin
            wdt_q      <= wdt_out;
            wdt_en_q   <= wdt_en_d;
            cause_q    <= cause_d;
            width_q    <= width_d;
            bite_cnt_q <= bite_cnt_d;
        end
    end

    logic [7:0] csr_rdata;

    always_comb begin
        csr_rdata = 8'd0;
        if (csr_hit) begin
            case (csr_off)
                R_CTRL:  csr_rdata = {5'd0, wdt_en_q, 1'b0};
                R_CAUSE: csr_rdata = {4'd0, cause_q};
                R_WIDTH: csr_rdata = width_q;
                default: csr_rdata = bite_cnt_q;
            endcase
        end
    end

    assign csr.csr_do = csr_rdata;

    state_e     state_q, state_d;
    logic       soc_rst_n_q, busy_q;
    logic       cd_load, cd_done;
    logic [7:0] cd_val;

    always_comb begin
        state_d = state_q;
        cd_load = 1'b0;
        cd_val  = at_least_one(width_q);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    cd_load = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (cd_done) begin
                    state_d = ST_HOLDOFF;
                    cd_load = 1'b1;
                    cd_val  = at_least_one(HOLDOFF);
                end
            end
            ST_HOLDOFF: begin
                if (cd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    tick_countdown u_countdown (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .load     (cd_load),
        .load_val (cd_val),
        .done     (cd_done)
    );

    // Outputs follow the registered state, so the pulse starts one edge after entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            soc_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            soc_rst_n_q <= (state_q != ST_ASSERT);
            busy_q      <= (state_q != ST_IDLE);
        end
    end

    assign soc_rst_n = soc_rst_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: CSR vector table, directed pulse
// sequences, then randomized traffic against an edge-numbered reference model.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [1:0] wdt_out;
    logic       frm;
    logic       soc_rst_n;
    logic       busy;

    rst_sequencer_if bus ();

    rst_sequencer #(
        .BASE_ADDR (5'h4),
        .DFL_WIDTH (8'h10),
        .HOLDOFF   (8'h20)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ce                  (ce),
        .csr                 (bus),
        .wdt_out             (wdt_out),
        .force_recovery_mode (frm),
        .soc_rst_n           (soc_rst_n),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam int HOLD = 32;

    typedef struct {
        bit         we;
        logic [4:0] a;
        logic [7:0] di;
        logic [4:0] ra;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[10];

    // Reference model state (random phase)
    int         edge_n;
    int         m_start;
    int         m_w;
    logic [1:0] m_prev;
    logic [1:0] m_en;
    logic [3:0] m_cause;
    logic [7:0] m_cnt;
    logic [7:0] m_width;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        bus.csr_a  = a;
        bus.csr_di = d;
        bus.csr_we = 1'b1;
        step();
        bus.csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
        bus.csr_we = 1'b0;
        bus.csr_a  = a;
        @(negedge clk);
        d = bus.csr_do;
        step();
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        step();
        chk("wait_idle_busy", busy, 1'b0);
    endtask

    // Samples outputs each cycle; optionally injects a wdt1 edge plus a WIDTH
    // write at cycle evt_k, and drives ce as one pulse every ce_period cycles.
    task automatic measure(input int ncyc, input int evt_k, input int ce_period,
                           output int low_cnt, output int busy_cnt,
                           output int starts, output int first_low);
        logic prev;
        prev      = 1'b1;
        low_cnt   = 0;
        busy_cnt  = 0;
        starts    = 0;
        first_low = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (!soc_rst_n) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
                if (prev) starts++;
            end
            prev = soc_rst_n;
            if (busy) busy_cnt++;
            if (k == evt_k) begin
                wdt_out    = 2'b11;
                bus.csr_a  = 5'h6;
                bus.csr_di = 8'h01;
                bus.csr_we = 1'b1;
            end else begin
                bus.csr_we = 1'b0;
            end
            step();
            ce = (ce_period == 1) ? 1'b1 : (((k + 1) % ce_period) == 0);
        end
        bus.csr_we = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [4:0] a);
        logic [4:0] off;
        off = a - 5'd4;
        if (off > 5'd3) return 8'd0;
        case (off[1:0])
            2'd0:    return {5'd0, m_en, 1'b0};
            2'd1:    return {4'd0, m_cause};
            2'd2:    return m_width;
            default: return m_cnt;
        endcase
    endfunction

    // Applies the register rules for the edge about to happen, using the inputs now on the pins.
    task automatic model_edge();
        int         m;
        logic [4:0] off;
        bit         hit, req0, req1, sw, any;
        m    = edge_n + 1;
        off  = bus.csr_a - 5'd4;
        hit  = bus.csr_we && (off <= 5'd3);
        req0 = wdt_out[0] && !m_prev[0] && m_en[0];
        req1 = wdt_out[1] && !m_prev[1] && m_en[1];
        sw   = hit && (off == 5'd0) && bus.csr_di[0];
        any  = req0 || req1 || sw;
        if (any && (m >= m_start + m_w + HOLD + 1)) begin
            m_start = m;
            m_w     = (m_width == 8'd0) ? 1 : int'(m_width);
        end
        if (hit && off == 5'd1) m_cause = m_cause & ~bus.csr_di[3:0];
        m_cause = m_cause | {any && frm, sw, req1, req0};
        if (req0 || req1) begin
            if (hit && off == 5'd3) m_cnt = 8'd1;
            else if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        end else if (hit && off == 5'd3) begin
            m_cnt = 8'd0;
        end
        if (hit && off == 5'd0) m_en = bus.csr_di[2:1];
        if (hit && off == 5'd2) m_width = bus.csr_di;
        m_prev = wdt_out;
        edge_n = m;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int lo, bz, st, fl;
        bit exp_low, exp_busy;

        tbl[0] = '{0, 5'h0, 8'h00, 5'h4, 8'h06, "ctrl_reset"};
        tbl[1] = '{0, 5'h0, 8'h00, 5'h5, 8'h00, "cause_reset"};
        tbl[2] = '{0, 5'h0, 8'h00, 5'h6, 8'h10, "width_reset"};
        tbl[3] = '{0, 5'h0, 8'h00, 5'h7, 8'h00, "cnt_reset"};
        tbl[4] = '{0, 5'h0, 8'h00, 5'h0, 8'h00, "unmapped_0"};
        tbl[5] = '{0, 5'h0, 8'h00, 5'h8, 8'h00, "unmapped_8"};
        tbl[6] = '{1, 5'h6, 8'h00, 5'h6, 8'h00, "width_zero"};
        tbl[7] = '{1, 5'h6, 8'h04, 5'h6, 8'h04, "width_write"};
        tbl[8] = '{1, 5'h4, 8'h06, 5'h4, 8'h06, "ctrl_write"};
        tbl[9] = '{1, 5'h3, 8'hff, 5'h3, 8'h00, "unmapped_write"};

        rst_n      = 1'b0;
        ce         = 1'b1;
        wdt_out    = 2'b00;
        frm        = 1'b0;
        bus.csr_a  = 5'h0;
        bus.csr_di = 8'h00;
        bus.csr_we = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_soc_rst_n", soc_rst_n, 1'b1);
        chk("reset_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) csr_write(tbl[i].a, tbl[i].di);
            csr_read(tbl[i].ra, d);
            $display("vec %0d %s: we=%0d a=%0h di=%0h read[%0h]=%0h exp=%0h",
                     i, tbl[i].name, tbl[i].we, tbl[i].a, tbl[i].di, tbl[i].ra, d, tbl[i].exp);
            chk(tbl[i].name, d, tbl[i].exp);
        end

        // Stuck-high wdt0 bite with WIDTH=4 and ce tied high
        wdt_out = 2'b01;
        measure(60, -1, 1, lo, bz, st, fl);
        $display("seq wdt0_bite: low=%0d busy=%0d starts=%0d first_low=%0d", lo, bz, st, fl);
        chk("bite_low_cycles", lo, 4);
        chk("bite_busy_cycles", bz, 4 + HOLD);
        chk("bite_pulse_count", st, 1);
        chk("bite_first_low", fl, 2);
        csr_read(5'h5, d);
        chk("bite_cause", d, 8'h01);
        csr_read(5'h7, d);
        chk("bite_cnt", d, 8'h01);

        // Software reset while in recovery mode
        csr_write(5'h5, 8'hff);
        frm = 1'b1;
        csr_write(5'h4, 8'h01);
        frm = 1'b0;
        measure(50, -1, 1, lo, bz, st, fl);
        $display("seq swrst: low=%0d starts=%0d first_low=%0d", lo, st, fl);
        chk("sw_low_cycles", lo, 4);
        chk("sw_pulse_count", st, 1);
        chk("sw_first_low", fl, 1);
        csr_read(5'h5, d);
        chk("sw_cause", d, 8'h0c);
        csr_read(5'h7, d);
        chk("sw_cnt_unchanged", d, 8'h01);
        csr_write(5'h5, 8'h04);
        csr_read(5'h5, d);
        chk("cause_w1c", d, 8'h08);
        csr_read(5'h4, d);
        chk("ctrl_after_swrst", d, 8'h00);

        // Masked channel: wdt1 edge with only wdt0 routed
        csr_write(5'h4, 8'h02);
        wdt_out = 2'b11;
        measure(10, -1, 1, lo, bz, st, fl);
        $display("seq masked_wdt1: starts=%0d busy=%0d", st, bz);
        chk("masked_pulse_count", st, 0);
        csr_read(5'h5, d);
        chk("masked_cause", d, 8'h08);
        csr_read(5'h7, d);
        chk("masked_cnt", d, 8'h01);

        // wdt1 bite and WIDTH write during ASSERT
        csr_write(5'h4, 8'h06);
        csr_write(5'h5, 8'hff);
        csr_write(5'h7, 8'h00);
        csr_write(5'h6, 8'h06);
        wdt_out = 2'b00;
        step();
        wdt_out = 2'b01;
        measure(60, 3, 1, lo, bz, st, fl);
        $display("seq bite_in_assert: low=%0d busy=%0d starts=%0d first_low=%0d", lo, bz, st, fl);
        chk("inassert_low_cycles", lo, 6);
        chk("inassert_busy_cycles", bz, 6 + HOLD);
        chk("inassert_pulse_count", st, 1);
        csr_read(5'h5, d);
        chk("inassert_cause", d, 8'h03);
        csr_read(5'h7, d);
        chk("inassert_cnt", d, 8'h02);
        csr_read(5'h6, d);
        chk("inassert_width", d, 8'h01);

        // CNT write on the same cycle as a bite
        wdt_out = 2'b00;
        step();
        wdt_out = 2'b01;
        csr_write(5'h7, 8'h55);
        csr_read(5'h7, d);
        $display("seq cnt_write_vs_bite: cnt=%0h", d);
        chk("cnt_write_vs_bite", d, 8'h01);

        // Saturation after many bites
        for (int i = 0; i < 256; i++) begin
            wdt_out = 2'b00;
            step();
            wdt_out = 2'b01;
            step();
        end
        csr_read(5'h7, d);
        $display("seq cnt_saturate: cnt=%0h", d);
        chk("cnt_saturate", d, 8'hff);
        wait_idle(200);

        // Sparse ce: WIDTH=3, one tick every 4 cycles
        csr_write(5'h6, 8'h03);
        ce = 1'b0;
        csr_write(5'h4, 8'h07);
        measure(220, -1, 4, lo, bz, st, fl);
        ce = 1'b1;
        $display("seq sparse_ce: low=%0d starts=%0d", lo, st);
        chk("sparse_low_in_range", (lo >= 9 && lo <= 13), 1'b1);
        chk("sparse_pulse_count", st, 1);
        wait_idle(200);

        // Power-on reset in the middle of a pulse
        csr_write(5'h4, 8'h07);
        step();
        @(negedge clk);
        chk("midpulse_soc_low", soc_rst_n, 1'b0);
        bus.csr_a = 5'h5;
        #2;
        rst_n = 1'b0;
        #1;
        $display("seq async_reset: soc_rst_n=%0b busy=%0b cause=%0h", soc_rst_n, busy, bus.csr_do);
        chk("async_reset_soc_rst_n", soc_rst_n, 1'b1);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_cause", bus.csr_do, 8'h00);
        step();
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        edge_n  = 0;
        m_start = -100000;
        m_w     = 1;
        m_prev  = 2'b00;
        m_en    = 2'b11;
        m_cause = 4'd0;
        m_cnt   = 8'd0;
        m_width = 8'h10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) wdt_out[0] = ~wdt_out[0];
            if ($urandom_range(0, 7) == 0) wdt_out[1] = ~wdt_out[1];
            if ($urandom_range(0, 15) == 0) frm = ~frm;
            case ($urandom_range(0, 19))
                0: begin
                    bus.csr_a  = 5'h4;
                    bus.csr_di = {5'd0, 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0)};
                    bus.csr_we = 1'b1;
                end
                1: begin
                    bus.csr_a  = 5'h5;
                    bus.csr_di = 8'($urandom);
                    bus.csr_we = 1'b1;
                end
                2: begin
                    bus.csr_a  = 5'h7;
                    bus.csr_di = 8'($urandom);
                    bus.csr_we = 1'b1;
                end
                3: begin
                    bus.csr_a  = 5'h6;
                    bus.csr_di = 8'($urandom_range(0, 5));
                    bus.csr_we = 1'b1;
                end
                default: begin
                    bus.csr_a  = 5'($urandom_range(0, 31));
                    bus.csr_di = 8'($urandom);
                    bus.csr_we = 1'b0;
                end
            endcase
            @(negedge clk);
            exp_low  = (edge_n >= m_start + 1) && (edge_n <= m_start + m_w);
            exp_busy = (edge_n >= m_start + 1) && (edge_n <= m_start + m_w + HOLD);
            chk("rnd_soc_rst_n", soc_rst_n, !exp_low);
            chk("rnd_busy", busy, exp_busy);
            chk("rnd_csr_do", bus.csr_do, m_read(bus.csr_a));
            model_edge();
            step();
        end
        bus.csr_we = 1'b0;
        $display("seq random: cycles=3000 checks_so_far=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
